// File: rtl/alu_pkg.sv
// Shared ALU control codes, RV32I major opcodes and ALU operand-A select encodings.
// Used by the decoder here and by the execute-stage ALU.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLTS = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_EQ   = 5'b11000;
    localparam logic [4:0] ALU_NE   = 5'b11001;
    localparam logic [4:0] ALU_LTS  = 5'b11100;
    localparam logic [4:0] ALU_GES  = 5'b11101;
    localparam logic [4:0] ALU_LTU  = 5'b11110;
    localparam logic [4:0] ALU_GEU  = 5'b11111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ASEL_RS1  = 2'd0,
        ASEL_PC   = 2'd1,
        ASEL_ZERO = 2'd2
    } a_sel_e;

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction, format chosen by the major opcode.
// OP-IMM shifts yield the zero-extended shift amount rather than the raw I-immediate.
module imm_gen
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM: begin
                if (instr[13:12] == 2'b01)
                    imm = {27'd0, instr[24:20]};
                else
                    imm = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'd0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I decode stage: combinational decode of the fetched word, captured into a
// single valid/ready pipeline register that execute can flush on a taken branch or jump.
module instr_decode_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_op,
    output logic [1:0]  a_sel,
    output logic        b_sel,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        wb_en,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        branch,
    output logic        jump,
    output logic        illegal,
    output logic [31:0] pc_out,
    output logic [7:0]  illegal_cnt
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] dec_imm;
    logic [4:0]  dec_alu_op;
    logic [1:0]  dec_a_sel;
    logic        dec_b_sel;
    logic        dec_wb_en;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic        dec_branch;
    logic        dec_jump;
    logic        dec_legal;
    logic        accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (dec_imm)
    );

    always_comb begin
        dec_alu_op = ALU_ADD;
        dec_a_sel  = ASEL_RS1;
        dec_b_sel  = 1'b0;
        dec_wb_en  = 1'b0;
        dec_mem_rd = 1'b0;
        dec_mem_wr = 1'b0;
        dec_branch = 1'b0;
        dec_jump   = 1'b0;
        dec_legal  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_alu_op = {1'b0, funct7[5], funct3};
                dec_wb_en  = 1'b1;
                dec_legal  = (funct7 == 7'b0000000) ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                dec_b_sel = 1'b1;
                dec_wb_en = 1'b1;
                case (funct3)
                    3'b001: begin
                        dec_alu_op = ALU_SLL;
                        dec_legal  = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        dec_alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec_legal  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    default: begin
                        dec_alu_op = {2'b00, funct3};
                        dec_legal  = 1'b1;
                    end
                endcase
            end
            OPC_BRANCH: begin
                dec_alu_op = {2'b11, funct3};
                dec_branch = 1'b1;
                dec_legal  = (funct3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                dec_b_sel  = 1'b1;
                dec_mem_rd = 1'b1;
                dec_wb_en  = 1'b1;
                dec_legal  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OPC_STORE: begin
                dec_b_sel  = 1'b1;
                dec_mem_wr = 1'b1;
                dec_legal  = (funct3 <= 3'b010);
            end
            OPC_LUI: begin
                dec_a_sel = ASEL_ZERO;
                dec_b_sel = 1'b1;
                dec_wb_en = 1'b1;
                dec_legal = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a_sel = ASEL_PC;
                dec_b_sel = 1'b1;
                dec_wb_en = 1'b1;
                dec_legal = 1'b1;
            end
            OPC_JAL: begin
                dec_a_sel = ASEL_PC;
                dec_b_sel = 1'b1;
                dec_jump  = 1'b1;
                dec_wb_en = 1'b1;
                dec_legal = 1'b1;
            end
            OPC_JALR: begin
                dec_b_sel = 1'b1;
                dec_jump  = 1'b1;
                dec_wb_en = 1'b1;
                dec_legal = (funct3 == 3'b000);
            end
            default: dec_legal = 1'b0;
        endcase

        // An illegal word must not trigger any side effect downstream.
        if (!dec_legal) begin
            dec_alu_op = ALU_ADD;
            dec_wb_en  = 1'b0;
            dec_mem_rd = 1'b0;
            dec_mem_wr = 1'b0;
            dec_branch = 1'b0;
            dec_jump   = 1'b0;
        end
        if (in_instr[11:7] == 5'd0)
            dec_wb_en = 1'b0;
    end

    assign in_ready = (~out_valid | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_op      <= ALU_ADD;
            a_sel       <= 2'd0;
            b_sel       <= 1'b0;
            imm         <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            wb_en       <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            branch      <= 1'b0;
            jump        <= 1'b0;
            illegal     <= 1'b0;
            pc_out      <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_op    <= dec_alu_op;
            a_sel     <= dec_a_sel;
            b_sel     <= dec_b_sel;
            imm       <= dec_imm;
            rs1       <= in_instr[19:15];
            rs2       <= in_instr[24:20];
            rd        <= in_instr[11:7];
            wb_en     <= dec_wb_en;
            mem_rd    <= dec_mem_rd;
            mem_wr    <= dec_mem_wr;
            branch    <= dec_branch;
            jump      <= dec_jump;
            illegal   <= ~dec_legal;
            pc_out    <= in_pc;
            if (!dec_legal && illegal_cnt != 8'hFF)
                illegal_cnt <= illegal_cnt + 8'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios plus a randomized
// handshake/decode run checked against an instruction-level reference model.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        wb_en, mem_rd, mem_wr, branch, jump, illegal;
    logic [31:0] pc_out;
    logic [7:0]  illegal_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_cnt = 0;

    instr_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd), .wb_en(wb_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .branch(branch), .jump(jump), .illegal(illegal), .pc_out(pc_out),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed bundle, packed: {illegal, wb, mrd, mwr, br, jmp, alu, asel, bsel, rs1, rs2, rd, imm, pc}
    function automatic logic [92:0] obs();
        return {illegal, wb_en, mem_rd, mem_wr, branch, jump, alu_op, a_sel, b_sel,
                rs1, rs2, rd, imm, pc_out};
    endfunction

    // Reference decode from the instruction-set rules; m masks fields the rules leave open.
    function automatic void ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                       output logic [92:0] e, output logic [92:0] m);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int i_imm, s_imm, b_imm, u_imm, j_imm, immv;
        bit legal, wb, mrd, mwr, br, jmp, bsel, chk_imm, chk_b;
        logic [4:0] alu;
        logic [1:0] asel;
        logic [31:0] imm_bits;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        i_imm = int'(w[31:20]) - (w[31] ? 4096 : 0);
        s_imm = int'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
        b_imm = int'({w[31], w[7], w[30:25], w[11:8]}) * 2 - (w[31] ? 8192 : 0);
        u_imm = int'(w[31:12]) << 12;
        j_imm = int'({w[31], w[19:12], w[20], w[30:21]}) * 2 - (w[31] ? (1 << 21) : 0);
        legal = 1; wb = 0; mrd = 0; mwr = 0; br = 0; jmp = 0; bsel = 0;
        chk_imm = 1; chk_b = 1; alu = 5'd0; asel = 2'd0; immv = 0;
        case (op)
            7'h33: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                alu = {1'b0, f7[5], f3}; wb = 1; chk_imm = 0;
            end
            7'h13: begin
                bsel = 1; wb = 1; immv = i_imm; alu = {2'b00, f3};
                if (f3 == 3'd1) begin
                    legal = (f7 == 7'h00); immv = int'(w[24:20]);
                end else if (f3 == 3'd5) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20); immv = int'(w[24:20]);
                    alu = (f7 == 7'h20) ? 5'b01101 : 5'b00101;
                end
            end
            7'h63: begin legal = (f3 != 3'd2 && f3 != 3'd3); alu = {2'b11, f3}; br = 1; immv = b_imm; end
            7'h03: begin legal = (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5); mrd = 1; wb = 1; bsel = 1; immv = i_imm; end
            7'h23: begin legal = (f3 <= 3'd2); mwr = 1; bsel = 1; immv = s_imm; end
            7'h37: begin asel = 2'd2; wb = 1; bsel = 1; immv = u_imm; end
            7'h17: begin asel = 2'd1; wb = 1; bsel = 1; immv = u_imm; end
            7'h6F: begin asel = 2'd1; wb = 1; jmp = 1; immv = j_imm; chk_b = 0; end
            7'h67: begin legal = (f3 == 3'd0); wb = 1; jmp = 1; immv = i_imm; chk_b = 0; end
            default: legal = 0;
        endcase
        if (!legal) begin
            alu = 5'd0; wb = 0; mrd = 0; mwr = 0; br = 0; jmp = 0; chk_imm = 0; chk_b = 0;
        end
        if (w[11:7] == 5'd0) wb = 0;
        imm_bits = immv;
        e = {!legal, wb, mrd, mwr, br, jmp, alu, asel, bsel, w[19:15], w[24:20], w[11:7], imm_bits, pc};
        m = {6'h3F, 5'h1F, (legal ? 2'b11 : 2'b00), chk_b, 15'h7FFF,
             (chk_imm ? 32'hFFFF_FFFF : 32'h0), 32'hFFFF_FFFF};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0] ops [10];
        logic [31:0] w;
        int k;
        ops = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) w[6:0] = ops[k];
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(); tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (illegal_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", illegal_cnt); end
        tests_run++;
        if (obs() !== 93'd0) begin tests_failed++; $display("FAIL reset_bundle: got %h expected 0", obs()); end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        exp_cnt = 0;
    endtask

    task automatic test_add();
        logic [92:0] e, m;
        in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h100; out_ready = 1;
        tick();
        in_valid = 0;
        $display("[TB] add pc=%h instr=%h alu_op=%b", pc_out, 32'h002081B3, alu_op);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_valid: got %b expected 1", out_valid); end
        tests_run++;
        if ({alu_op, rs1, rs2, rd, wb_en, b_sel} !== {5'b00000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_fields: got alu=%b rs1=%0d rs2=%0d rd=%0d wb=%b bsel=%b expected 00000 1 2 3 1 0",
                     alu_op, rs1, rs2, rd, wb_en, b_sel);
        end
        ref_decode(32'h002081B3, 32'h100, e, m);
        tests_run++;
        if ((obs() & m) !== (e & m)) begin tests_failed++; $display("FAIL add_model: got %h expected %h", obs() & m, e & m); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL add_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1; in_valid = 1; in_instr = 32'h402081B3; in_pc = 32'h200;
        tick();
        in_instr = 32'h40335293; in_pc = 32'h204;
        $display("[TB] sub pc=%h alu_op=%b", pc_out, alu_op);
        tests_run++;
        if ({out_valid, alu_op, pc_out} !== {1'b1, 5'b01000, 32'h200}) begin
            tests_failed++; $display("FAIL b2b_sub: got v=%b alu=%b pc=%h expected 1 01000 200", out_valid, alu_op, pc_out);
        end
        tick();
        in_valid = 0;
        $display("[TB] srai pc=%h alu_op=%b imm=%h", pc_out, alu_op, imm);
        tests_run++;
        if ({out_valid, alu_op, imm, b_sel, rd, pc_out} !== {1'b1, 5'b01101, 32'd3, 1'b1, 5'd5, 32'h204}) begin
            tests_failed++;
            $display("FAIL b2b_srai: got v=%b alu=%b imm=%h bsel=%b rd=%0d pc=%h expected 1 01101 3 1 5 204",
                     out_valid, alu_op, imm, b_sel, rd, pc_out);
        end
        tick();
    endtask

    task automatic test_branch();
        out_ready = 1; in_valid = 1; in_instr = 32'h00208463; in_pc = 32'h300;
        tick();
        in_valid = 0;
        $display("[TB] beq pc=%h alu_op=%b imm=%h", pc_out, alu_op, imm);
        tests_run++;
        if ({out_valid, alu_op, imm, branch, wb_en, b_sel} !== {1'b1, 5'b11000, 32'd8, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL beq: got v=%b alu=%b imm=%h br=%b wb=%b bsel=%b expected 1 11000 8 1 0 0",
                     out_valid, alu_op, imm, branch, wb_en, b_sel);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [92:0] ea, ma, eb, mb;
        ref_decode(32'h00500393, 32'h400, ea, ma);
        ref_decode(32'h123454B7, 32'h404, eb, mb);
        out_ready = 0; in_valid = 1; in_instr = 32'h00500393; in_pc = 32'h400;
        tick();
        in_instr = 32'h123454B7; in_pc = 32'h404;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({out_valid, in_ready} !== 2'b10 || (obs() & ma) !== (ea & ma)) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got v=%b rdy=%b bundle=%h expected 1 0 %h",
                         k, out_valid, in_ready, obs() & ma, ea & ma);
            end
            tick();
        end
        out_ready = 1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 0;
        $display("[TB] lui pc=%h imm=%h", pc_out, imm);
        tests_run++;
        if (out_valid !== 1'b1 || (obs() & mb) !== (eb & mb)) begin
            tests_failed++; $display("FAIL stall_next: got v=%b bundle=%h expected 1 %h", out_valid, obs() & mb, eb & mb);
        end
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1; in_valid = 1; in_instr = 32'h0; in_pc = 32'h500;
        tick();
        in_valid = 0;
        exp_cnt = 1;
        $display("[TB] illegal pc=%h cnt=%0d", pc_out, illegal_cnt);
        tests_run++;
        if ({out_valid, illegal, wb_en, mem_rd, mem_wr, branch, jump, alu_op} !== {2'b11, 5'b0, 5'b0}) begin
            tests_failed++;
            $display("FAIL illegal_flags: got v=%b ill=%b en=%b%b%b%b%b alu=%b expected 1 1 00000 00000",
                     out_valid, illegal, wb_en, mem_rd, mem_wr, branch, jump, alu_op);
        end
        tests_run++;
        if (illegal_cnt !== 8'd1) begin tests_failed++; $display("FAIL illegal_cnt1: got %0d expected 1", illegal_cnt); end
        tick();
    endtask

    task automatic test_random();
        bit m_valid = 0;
        logic [92:0] m_exp = '0, m_mask = '0, e, m;
        bit exp_rdy, acc;
        out_ready = 1; in_valid = 0; flush = 0;
        tick(); tick();
        for (int c = 0; c < 400; c++) begin
            tests_run++;
            if (out_valid !== m_valid) begin tests_failed++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, out_valid, m_valid); end
            if (m_valid) begin
                tests_run++;
                if ((obs() & m_mask) !== (m_exp & m_mask)) begin
                    tests_failed++; $display("FAIL rnd_bundle c=%0d: got %h expected %h", c, obs() & m_mask, m_exp & m_mask);
                end
            end
            tests_run++;
            if (illegal_cnt !== exp_cnt[7:0]) begin tests_failed++; $display("FAIL rnd_cnt c=%0d: got %0d expected %0d", c, illegal_cnt, exp_cnt); end
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            in_instr = gen_instr();
            in_pc = $urandom & 32'hFFFF_FFFC;
            #1;
            exp_rdy = (!m_valid || out_ready) && !flush;
            tests_run++;
            if (in_ready !== exp_rdy) begin tests_failed++; $display("FAIL rnd_in_ready c=%0d: got %b expected %b", c, in_ready, exp_rdy); end
            acc = in_valid && exp_rdy;
            ref_decode(in_instr, in_pc, e, m);
            @(posedge clk);
            if (flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_exp = e; m_mask = m;
                if (e[92] && exp_cnt < 255) exp_cnt++;
                $display("[TB] rnd accept pc=%h instr=%h illegal=%b", in_pc, in_instr, e[92]);
            end else if (out_ready) m_valid = 0;
            #1;
        end
        in_valid = 0; flush = 0; out_ready = 1;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_instr = 32'h00500393; in_pc = 32'h600;
        tick();
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL flush_pre: got %b expected 1", out_valid); end
        flush = 1; in_instr = 32'hFFFF_FFFF; in_pc = 32'h604;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        tick();
        flush = 0; in_valid = 0;
        $display("[TB] flush pc=%h", 32'h600);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || illegal_cnt !== exp_cnt[7:0]) begin
            tests_failed++; $display("FAIL flush_not_accepted: got v=%b cnt=%0d expected 0 %0d", out_valid, illegal_cnt, exp_cnt);
        end
        out_ready = 1;
    endtask

    task automatic test_saturate();
        out_ready = 1; in_valid = 1; in_instr = 32'h0;
        for (int k = 0; k < 300; k++) begin
            in_pc = k * 4;
            tick();
        end
        in_valid = 0;
        tick();
        $display("[TB] saturate cnt=%0d", illegal_cnt);
        tests_run++;
        if (illegal_cnt !== 8'd255) begin tests_failed++; $display("FAIL cnt_saturate: got %0d expected 255", illegal_cnt); end
    endtask

    task automatic test_async_reset();
        out_ready = 0; in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h700;
        tick();
        in_valid = 0;
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL areset_pre: got %b expected 1", out_valid); end
        #2 rst_n = 0;
        #1;
        tests_run++;
        if ({out_valid, illegal_cnt, obs()} !== '0) begin
            tests_failed++; $display("FAIL areset_clear: got v=%b cnt=%0d bundle=%h expected all 0", out_valid, illegal_cnt, obs());
        end
        tick();
        rst_n = 1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL areset_release: got rdy=%b v=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_branch();
        test_stall();
        test_illegal();
        test_random();
        test_flush();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
